// File: rtl/issue_queue_index_free_list_pkg.sv
// issue_queue_index_free_list_pkg: scheduler-wide issue-queue index types and flush-return walk geometry
package SchedulerTypes;
    localparam int ISSUE_QUEUE_ENTRY_NUM = 16;
    localparam int DISPATCH_WIDTH = 2;
    localparam int ISSUE_WIDTH = 2;
    localparam int ISSUE_QUEUE_INDEX_BIT_SIZE = $clog2(ISSUE_QUEUE_ENTRY_NUM);
    localparam int ISSUE_QUEUE_RETURN_INDEX_WIDTH = 2;
    localparam int ISSUE_QUEUE_RETURN_INDEX_CYCLE =
        (ISSUE_QUEUE_ENTRY_NUM + ISSUE_QUEUE_RETURN_INDEX_WIDTH - 1) / ISSUE_QUEUE_RETURN_INDEX_WIDTH;
    localparam int ISSUE_QUEUE_RETURN_INDEX_CYCLE_BIT_SIZE = $clog2(ISSUE_QUEUE_RETURN_INDEX_CYCLE);

    typedef logic [ISSUE_QUEUE_INDEX_BIT_SIZE-1:0] IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_INDEX_BIT_SIZE:0]   IssueQueueCountPath;
    typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]      IssueQueueOneHotPath;

    typedef enum logic {IQFL_IDLE, IQFL_RETURN} IQFreeListPhase;
endpackage

// File: rtl/issue_queue_index_free_list_scanner.sv
// iq_flush_return_scanner: latches a flush mask and walks it chunk by chunk, emitting indices to return
module iq_flush_return_scanner
    import SchedulerTypes::*;
#(
    parameter int ENTRY_NUM    = ISSUE_QUEUE_ENTRY_NUM,
    parameter int RETURN_WIDTH = ISSUE_QUEUE_RETURN_INDEX_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_flushStart,
    input  logic [ENTRY_NUM-1:0]                          i_flushMask,
    output logic                                          o_flushBusy,
    output logic [ENTRY_NUM-1:0]                          o_mask,
    output logic [RETURN_WIDTH-1:0]                       o_returnValid,
    output logic [RETURN_WIDTH-1:0][$clog2(ENTRY_NUM)-1:0] o_returnPtr
);
    localparam int IDX_W  = $clog2(ENTRY_NUM);
    localparam int CYCLE  = (ENTRY_NUM + RETURN_WIDTH - 1) / RETURN_WIDTH;
    localparam int C_W    = CYCLE > 1 ? $clog2(CYCLE) : 1;
    localparam int MASK_W = CYCLE * RETURN_WIDTH;

    IQFreeListPhase                         r_state, w_state_next;
    logic [C_W-1:0]                         r_c, w_c_next;
    logic [CYCLE-1:0][RETURN_WIDTH-1:0]     r_mask, w_mask_next;
    logic [MASK_W-1:0]                      w_mask_flat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IQFL_IDLE;
            r_c     <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            r_c     <= w_c_next;
            r_mask  <= w_mask_next;
        end
    end

    // Zero-extending the mask makes last-chunk bits beyond ENTRY_NUM inert.
    always_comb begin
        w_state_next = r_state;
        w_c_next     = r_c;
        w_mask_next  = r_mask;
        if (r_state == IQFL_IDLE && i_flushStart) begin
            w_state_next = IQFL_RETURN;
            w_c_next     = '0;
            w_mask_next  = MASK_W'(i_flushMask);
        end else if (r_state == IQFL_RETURN) begin
            w_c_next     = r_c + C_W'(1);
            w_state_next = (r_c == C_W'(CYCLE - 1)) ? IQFL_IDLE : IQFL_RETURN;
        end
    end

    assign o_flushBusy = r_state == IQFL_RETURN;
    assign w_mask_flat = r_mask;
    assign o_mask      = w_mask_flat[ENTRY_NUM-1:0];

    for (genvar k = 0; k < RETURN_WIDTH; k++) begin : g_ret
        assign o_returnValid[k] = (r_state == IQFL_RETURN) && r_mask[r_c][k];
        assign o_returnPtr[k]   = IDX_W'(int'(r_c) * RETURN_WIDTH + k);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(i_flushStart && r_state != IQFL_IDLE))
                else $warning("flushStart ignored while return walk is busy");
    end
endmodule

// File: rtl/issue_queue_index_free_list.sv
// issue_queue_index_free_list: circular free list of issue-queue indices; dispatch pops,
// issue releases and a flush-mask walk push back, all packed contiguously each cycle.
module issue_queue_index_free_list
    import SchedulerTypes::*;
#(
    parameter int ENTRY_NUM     = ISSUE_QUEUE_ENTRY_NUM,
    parameter int ALLOC_WIDTH   = DISPATCH_WIDTH,
    parameter int RELEASE_WIDTH = ISSUE_WIDTH,
    parameter int RETURN_WIDTH  = ISSUE_QUEUE_RETURN_INDEX_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [ALLOC_WIDTH-1:0]                          i_allocReq,
    output logic [ALLOC_WIDTH-1:0][$clog2(ENTRY_NUM)-1:0]   o_allocPtr,
    output logic                                            o_allocReady,
    input  logic [RELEASE_WIDTH-1:0]                        i_releaseValid,
    input  logic [RELEASE_WIDTH-1:0][$clog2(ENTRY_NUM)-1:0] i_releasePtr,
    input  logic                                            i_flushStart,
    input  logic [ENTRY_NUM-1:0]                            i_flushMask,
    output logic                                            o_flushBusy,
    output logic [$clog2(ENTRY_NUM):0]                      o_freeCount
);
    localparam int IDX_W  = $clog2(ENTRY_NUM);
    localparam int PTR_W  = IDX_W + 1;
    localparam int PUSH_W = RELEASE_WIDTH + RETURN_WIDTH;

    logic [IDX_W-1:0]                   r_fifo [ENTRY_NUM];
    logic [PTR_W-1:0]                   r_head, r_tail;
    logic [PTR_W-1:0]                   w_pop_num, w_pops, w_push_num;
    logic [IDX_W-1:0]                   w_rd_idx [ALLOC_WIDTH];
    logic [IDX_W-1:0]                   w_wr_idx [PUSH_W];
    logic [PUSH_W-1:0]                  w_push_valid;
    logic [PUSH_W-1:0][IDX_W-1:0]       w_push_ptr;
    logic [RETURN_WIDTH-1:0]            w_return_valid;
    logic [RETURN_WIDTH-1:0][IDX_W-1:0] w_return_ptr;
    logic [ENTRY_NUM-1:0]               w_mask;

    iq_flush_return_scanner #(
        .ENTRY_NUM    (ENTRY_NUM),
        .RETURN_WIDTH (RETURN_WIDTH)
    ) u_scanner (
        .clk           (clk),
        .rst           (rst),
        .i_flushStart  (i_flushStart),
        .i_flushMask   (i_flushMask),
        .o_flushBusy   (o_flushBusy),
        .o_mask        (w_mask),
        .o_returnValid (w_return_valid),
        .o_returnPtr   (w_return_ptr)
    );

    // Release lanes precede return lanes in the tail packing order.
    assign w_push_valid = {w_return_valid, i_releaseValid};
    assign w_push_ptr   = {w_return_ptr, i_releasePtr};

    always_comb begin
        w_pop_num = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_rd_idx[i] = IDX_W'(r_head + w_pop_num);
            w_pop_num   = w_pop_num + PTR_W'(i_allocReq[i]);
        end
        w_push_num = '0;
        for (int j = 0; j < PUSH_W; j++) begin
            w_wr_idx[j] = IDX_W'(r_tail + w_push_num);
            w_push_num  = w_push_num + PTR_W'(w_push_valid[j]);
        end
    end

    for (genvar a = 0; a < ALLOC_WIDTH; a++) begin : g_alloc
        assign o_allocPtr[a] = r_fifo[w_rd_idx[a]];
    end

    assign o_freeCount  = r_tail - r_head;
    assign o_allocReady = (o_freeCount >= PTR_W'(ALLOC_WIDTH)) && !o_flushBusy;
    assign w_pops       = o_allocReady ? w_pop_num : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++)
                r_fifo[i] <= IDX_W'(i);
            r_head <= '0;
            r_tail <= PTR_W'(ENTRY_NUM);
        end else begin
            r_head <= r_head + w_pops;
            r_tail <= r_tail + w_push_num;
            for (int j = 0; j < PUSH_W; j++)
                if (w_push_valid[j])
                    r_fifo[w_wr_idx[j]] <= w_push_ptr[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(o_freeCount) + int'(w_push_num) - int'(w_pops) <= ENTRY_NUM)
                else $error("free list overflow");
            assert (!(|i_allocReq && int'(o_freeCount) < int'(w_pop_num)))
                else $error("allocation requested beyond free count");
            for (int j = 0; j < RELEASE_WIDTH; j++)
                assert (!(o_flushBusy && i_releaseValid[j] && w_mask[i_releasePtr[j]]))
                    else $error("released index %0d is also being flushed", i_releasePtr[j]);
        end
    end
endmodule

// File: tb/tb_issue_queue_index_free_list.sv
// tb_issue_queue_index_free_list: directed checks of pop/push ordering, flush walk, and reset abort
module tb_issue_queue_index_free_list;
    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      alloc_req;
    logic [1:0][3:0] alloc_ptr;
    logic            alloc_ready;
    logic [1:0]      release_valid;
    logic [1:0][3:0] release_ptr;
    logic            flush_start;
    logic [15:0]     flush_mask;
    logic            flush_busy;
    logic [4:0]      free_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt [8] = '{0, 1, 1, 3, 3, 3, 4, 4};

    issue_queue_index_free_list dut (
        .clk            (clk),
        .rst            (rst),
        .i_allocReq     (alloc_req),
        .o_allocPtr     (alloc_ptr),
        .o_allocReady   (alloc_ready),
        .i_releaseValid (release_valid),
        .i_releasePtr   (release_ptr),
        .i_flushStart   (flush_start),
        .i_flushMask    (flush_mask),
        .o_flushBusy    (flush_busy),
        .o_freeCount    (free_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        alloc_req = '0;
        release_valid = '0;
        release_ptr = '0;
        flush_start = 1'b0;
        flush_mask = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_count", free_count, 16);
        chk("reset_ready", alloc_ready, 1);
        chk("reset_busy", flush_busy, 0);
        // drain the reset list in pairs
        for (int i = 0; i < 8; i++) begin
            alloc_req = 2'b11;
            #1;
            chk("drain_ptr0", alloc_ptr[0], 2 * i);
            chk("drain_ptr1", alloc_ptr[1], 2 * i + 1);
            tick();
        end
        alloc_req = 2'b00;
        #1;
        chk("empty_count", free_count, 0);
        chk("empty_ready", alloc_ready, 0);
        release_valid = 2'b11;
        release_ptr[0] = 4'd5;
        release_ptr[1] = 4'd9;
        tick();
        release_valid = 2'b00;
        #1;
        chk("rel_count", free_count, 2);
        chk("rel_ready", alloc_ready, 1);
        alloc_req = 2'b10;
        #1;
        chk("lane1_only_ptr", alloc_ptr[1], 5);
        alloc_req = 2'b11;
        #1;
        chk("rel_ptr0", alloc_ptr[0], 5);
        chk("rel_ptr1", alloc_ptr[1], 9);
        tick();
        alloc_req = 2'b00;
        #1;
        chk("realloc_count", free_count, 0);
        // flush walk with mask 8421, release 7 in chunk 2, stray flushStart in chunk 3
        flush_start = 1'b1;
        flush_mask = 16'h8421;
        tick();
        flush_start = 1'b0;
        flush_mask = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            release_valid = (k == 2) ? 2'b01 : 2'b00;
            release_ptr[0] = 4'd7;
            flush_start = (k == 3);
            flush_mask = 16'hFFFF;
            #1;
            chk("walk_busy", flush_busy, 1);
            chk("walk_ready", alloc_ready, 0);
            chk("walk_count", free_count, exp_cnt[k]);
            tick();
        end
        release_valid = 2'b00;
        flush_start = 1'b0;
        flush_mask = 16'h0000;
        #1;
        chk("walk_done_busy", flush_busy, 0);
        chk("walk_done_count", free_count, 5);
        chk("walk_done_ready", alloc_ready, 1);
        alloc_req = 2'b11;
        #1;
        chk("order_ptr0", alloc_ptr[0], 0);
        chk("order_ptr1", alloc_ptr[1], 7);
        tick();
        #1;
        chk("order_ptr2", alloc_ptr[0], 5);
        chk("order_ptr3", alloc_ptr[1], 10);
        tick();
        alloc_req = 2'b00;
        #1;
        chk("post_walk_count", free_count, 1);
        // second walk aborted by reset in walk cycle 4
        flush_start = 1'b1;
        flush_mask = 16'h00F0;
        tick();
        flush_start = 1'b0;
        flush_mask = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("walk2_busy", flush_busy, 1);
            tick();
        end
        chk("walk2_count", free_count, 5);
        rst = 1'b1;
        #1;
        chk("abort_busy", flush_busy, 0);
        chk("abort_count", free_count, 16);
        tick();
        rst = 1'b0;
        alloc_req = 2'b11;
        #1;
        chk("abort_ptr0", alloc_ptr[0], 0);
        chk("abort_ptr1", alloc_ptr[1], 1);
        chk("abort_ready", alloc_ready, 1);
        tick();
        alloc_req = 2'b00;
        #1;
        chk("abort_alloc_count", free_count, 14);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
